// File: rtl/bus_timeout_monitor.sv
// bus_timeout_monitor: 68000 bus-cycle watchdog that raises BERR (optionally HALT+BERR for
// a rerun) when DTACK does not arrive within a programmable number of clocks.
module bus_timeout_monitor #(
  parameter int CNT_W       = 8,
  parameter int RESET_LIMIT = 127,
  parameter int RETRY_EN    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             as_n,
  input  logic             dtack_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit_in,
  input  logic             limit_we,
  input  logic             fault_clr,
  output logic             berr_n,
  output logic             halt_n,
  output logic             timeout,
  output logic [7:0]       fault_count
);
  typedef enum logic [1:0] {IDLE, COUNT, FAULT} state_t;
  localparam logic RE = (RETRY_EN != 0);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, r_limit;
  logic r_retry, r_berr_n, r_halt_n, r_timeout;
  logic [7:0] r_fc;
  logic w_term, w_hit, w_fault_entry;
  assign w_term = as_n | ~dtack_n | ~enable;
  assign w_hit = (r_cnt >= r_limit);
  // termination wins over a timeout in the same cycle
  assign w_fault_entry = (r_state == COUNT) && !w_term && w_hit;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (enable && !as_n) ? COUNT : IDLE;
      COUNT:   w_next = w_term ? IDLE : (w_hit ? FAULT : COUNT);
      FAULT:   w_next = as_n ? IDLE : FAULT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_limit   <= CNT_W'(RESET_LIMIT);
      r_retry   <= 1'b0;
      r_berr_n  <= 1'b1;
      r_halt_n  <= 1'b1;
      r_timeout <= 1'b0;
      r_fc      <= 8'd0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (r_state == COUNT && w_next == COUNT) ? r_cnt + CNT_W'(1) : '0;
      r_limit   <= limit_we ? limit_in : r_limit;
      r_berr_n  <= (w_next != FAULT);
      r_halt_n  <= w_fault_entry ? !(RE && !r_retry) : ((w_next == FAULT) ? r_halt_n : 1'b1);
      r_timeout <= w_fault_entry;
      if (!enable)
        r_retry <= 1'b0;
      else if (w_fault_entry && RE)
        r_retry <= !r_retry;
      else if (r_state == COUNT && !dtack_n)
        r_retry <= 1'b0;
      if (fault_clr)
        r_fc <= {7'd0, w_fault_entry};
      else if (w_fault_entry && r_fc != 8'hFF)
        r_fc <= r_fc + 8'd1;
    end
  end
  assign berr_n      = r_berr_n;
  assign halt_n      = r_halt_n;
  assign timeout     = r_timeout;
  assign fault_count = r_fc;
endmodule

// File: tb/tb_bus_timeout_monitor.sv
// tb_bus_timeout_monitor: directed table plus hand sequences against two instances,
// one plain (RETRY_EN=0) and one with the HALT+BERR rerun enabled.
module tb_bus_timeout_monitor;
  logic clk = 0, reset_n = 0;
  logic as_n = 1, dtack_n = 1, enable = 0, limit_we = 0, fault_clr = 0;
  logic [7:0] limit_in = 0;
  logic berr0, halt0, to0, berr1, halt1, to1;
  logic [7:0] fc0, fc1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bus_timeout_monitor #(.RETRY_EN(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .dtack_n(dtack_n), .enable(enable),
    .limit_in(limit_in), .limit_we(limit_we), .fault_clr(fault_clr),
    .berr_n(berr0), .halt_n(halt0), .timeout(to0), .fault_count(fc0));

  bus_timeout_monitor #(.RETRY_EN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .dtack_n(dtack_n), .enable(enable),
    .limit_in(limit_in), .limit_we(limit_we), .fault_clr(fault_clr),
    .berr_n(berr1), .halt_n(halt1), .timeout(to1), .fault_count(fc1));

  typedef struct {
    logic a, d, e, we;
    logic [7:0] lim;
    logic clr, eb, eh, et;
    logic [7:0] efc;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic a, d, e, we, input logic [7:0] lim, input logic clr);
    @(negedge clk);
    as_n = a; dtack_n = d; enable = e; limit_we = we; limit_in = lim; fault_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic a, d, e, we, input logic [7:0] lim, input logic clr,
                     input logic eb, eh, et, input logic [7:0] efc);
    vec_t v;
    v.a = a; v.d = d; v.e = e; v.we = we; v.lim = lim; v.clr = clr;
    v.eb = eb; v.eh = eh; v.et = et; v.efc = efc;
    vq.push_back(v);
  endtask

  task automatic add_n(input int n, input logic a, d, e, input logic eb, eh, et,
                       input logic [7:0] efc);
    for (int i = 0; i < n; i++) add(a, d, e, 0, 0, 0, eb, eh, et, efc);
  endtask

  // Default limit 127: BERR must fall on edge 128 after the COUNT-entry edge.
  task automatic run_default(input string tag, input logic [7:0] efc);
    int first_low = -1;
    logic ta = 0, tb = 0, h1 = 1;
    drive(0, 1, 1, 0, 0, 0);
    for (int e = 0; e <= 129; e++) begin
      tick();
      if (!berr0 && first_low < 0) first_low = e;
      if (e == 128) begin ta = to0; h1 = halt1; end
      if (e == 129) tb = to0;
    end
    chk({tag, "_berr_edge"}, first_low, 128);
    chk({tag, "_timeout_pulse"}, ta, 1);
    chk({tag, "_timeout_end"}, tb, 0);
    chk({tag, "_halt_retry"}, h1, 0);
    chk({tag, "_halt_plain"}, halt0, 1);
    chk({tag, "_fc"}, fc0, efc);
    drive(1, 1, 1, 0, 0, 0);
    tick();
    chk({tag, "_release_berr"}, berr0, 1);
    chk({tag, "_release_halt"}, halt1, 1);
  endtask

  task automatic one_timeout(input logic clr);
    drive(0, 1, 1, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, clr); tick();
    drive(1, 1, 1, 0, 0, 0); tick();
  endtask

  initial begin
    // limit 3 table: entry edge, three counting edges, FAULT on the fourth edge
    add(1, 1, 0, 1, 3, 1, 1, 1, 0, 0);
    add_n(4, 0, 1, 1, 1, 1, 0, 0);
    add_n(1, 0, 1, 1, 0, 0, 1, 1);
    add_n(1, 0, 0, 1, 0, 0, 0, 1);
    add_n(1, 1, 1, 1, 1, 1, 0, 1);
    add_n(4, 0, 1, 1, 1, 1, 0, 1);
    add_n(1, 0, 1, 1, 0, 1, 1, 2);
    add_n(1, 1, 1, 1, 1, 1, 0, 2);
    add_n(1, 0, 1, 1, 1, 1, 0, 2);
    add_n(1, 0, 0, 1, 1, 1, 0, 2);
    add_n(4, 0, 1, 1, 1, 1, 0, 2);
    add_n(1, 0, 0, 1, 1, 1, 0, 2);
    add_n(4, 0, 1, 1, 1, 1, 0, 2);
    add_n(1, 0, 1, 1, 0, 0, 1, 3);
    add_n(1, 1, 1, 1, 1, 1, 0, 3);
    add_n(1, 0, 1, 1, 1, 1, 0, 3);
    add_n(1, 0, 0, 1, 1, 1, 0, 3);
    add_n(4, 0, 1, 1, 1, 1, 0, 3);
    add_n(1, 0, 1, 1, 0, 0, 1, 4);
    add(1, 1, 1, 0, 0, 1, 1, 1, 0, 0);
    add_n(1, 0, 1, 1, 1, 1, 0, 0);
    add_n(2, 0, 1, 0, 1, 1, 0, 0);
    add_n(4, 0, 1, 1, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 1, 1);
    add_n(1, 0, 1, 0, 0, 0, 0, 1);
    add_n(1, 1, 1, 1, 1, 1, 0, 1);
    add(1, 1, 1, 1, 10, 0, 1, 1, 0, 1);
    add_n(6, 0, 1, 1, 1, 1, 0, 1);
    add(0, 1, 1, 1, 2, 0, 1, 1, 0, 1);
    add_n(1, 0, 1, 1, 0, 0, 1, 2);
    add_n(1, 1, 1, 1, 1, 1, 0, 2);
    add_n(1, 0, 1, 1, 1, 1, 0, 2);
    add_n(1, 1, 1, 1, 1, 1, 0, 2);

    #12;
    chk("reset_berr", berr0, 1);
    chk("reset_halt", halt1, 1);
    chk("reset_timeout", to1, 0);
    chk("reset_fc", fc1, 0);
    @(negedge clk) reset_n = 1;

    run_default("dflt", 1);

    foreach (vq[i]) begin
      drive(vq[i].a, vq[i].d, vq[i].e, vq[i].we, vq[i].lim, vq[i].clr);
      tick();
      chk($sformatf("row%0d_berr0", i), berr0, vq[i].eb);
      chk($sformatf("row%0d_halt0", i), halt0, 1);
      chk($sformatf("row%0d_to0", i), to0, vq[i].et);
      chk($sformatf("row%0d_fc0", i), fc0, vq[i].efc);
      chk($sformatf("row%0d_berr1", i), berr1, vq[i].eb);
      chk($sformatf("row%0d_halt1", i), halt1, vq[i].eh);
    end

    drive(1, 1, 1, 1, 0, 1); tick();
    chk("sat_clr", fc0, 0);
    for (int n = 0; n < 256; n++) one_timeout(0);
    chk("sat_255", fc0, 255);
    chk("sat_255_retry", fc1, 255);
    one_timeout(1);
    chk("sat_clr_with_timeout", fc0, 1);

    drive(0, 1, 1, 0, 0, 0); tick(); tick();
    chk("pre_reset_fault", berr0, 0);
    #2 reset_n = 0;
    #1;
    chk("async_berr0", berr0, 1);
    chk("async_berr1", berr1, 1);
    chk("async_halt1", halt1, 1);
    chk("async_fc", fc0, 0);
    drive(1, 1, 1, 0, 0, 0);
    reset_n = 1;
    run_default("post_reset", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_timeout_monitor.md
BUS_TIMEOUT_MONITOR -- requirements
Module: bus_timeout_monitor

Interface
REQ-001 Parameter CNT_W, default 8: timeout counter and limit width (>=2).
REQ-002 Parameter RESET_LIMIT, default 127: limit_q value after reset.
REQ-003 Parameter RETRY_EN, default 0: 1 enables the HALT+BERR rerun attempt before the final bus error.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 as_n  in  1  68000 address strobe, active-low, synchronous to clk.
REQ-007 dtack_n  in  1  data transfer acknowledge, active-low.
REQ-008 enable  in  1  monitor enable; 0 forces IDLE.
REQ-009 limit_in  in  CNT_W  new timeout limit.
REQ-010 limit_we  in  1  loads limit_in into limit_q.
REQ-011 fault_clr  in  1  clears fault_count.
REQ-012 berr_n  out  1  bus error, active-low, registered.
REQ-013 halt_n  out  1  halt for rerun, active-low, registered; held at 1 when RETRY_EN=0.
REQ-014 timeout  out  1  one-cycle pulse per detected timeout.
REQ-015 fault_count  out  8  saturating count of timeouts.

Function
REQ-016 FSM states SHALL be IDLE, COUNT and FAULT.
REQ-017 IDLE: berr_n=1, halt_n=1; if enable=1 and as_n=0, go to COUNT with counter=0.
REQ-018 COUNT: the cycle SHALL terminate to IDLE when dtack_n=0, or as_n=1, or enable=0.
REQ-019 COUNT: otherwise, if counter >= limit_q, go to FAULT; else counter increments by 1.
REQ-020 Timing: with limit L and no termination, berr_n SHALL go low on the (L+1)th rising edge after the edge that entered COUNT.
REQ-021 Termination in REQ-018 SHALL take priority over a timeout in the same cycle.
REQ-022 Comparison uses >=, so a limit_q lowered below the current counter causes FAULT on the next edge.
REQ-023 Entering FAULT: berr_n=0; timeout=1 for exactly one cycle; fault_count +1, saturating at 255.
REQ-024 FAULT: stays while as_n=0, regardless of dtack_n and enable; on as_n=1 go to IDLE with berr_n=1, halt_n=1 on the same edge.
REQ-025 RETRY_EN=1, first timeout of a bus access: halt_n=0 together with berr_n=0, and the retry_used flag is set.
REQ-026 RETRY_EN=1, timeout with retry_used=1: berr_n=0 only, halt_n=1, and retry_used is cleared.
REQ-027 retry_used SHALL also clear when a COUNT cycle terminates by dtack_n=0, or when enable=0.
REQ-028 limit_we=1 SHALL load limit_q on any edge in any state; the new value is compared from the next edge.
REQ-029 fault_clr=1 SHALL zero fault_count; fault_clr and an increment in the same cycle SHALL yield 1.
REQ-030 The counter SHALL never wrap, because it stops at limit_q.

Reset
REQ-031 reset_n=0 SHALL asynchronously force: state=IDLE, counter=0, limit_q=RESET_LIMIT, retry_used=0, berr_n=1, halt_n=1, timeout=0, fault_count=0.
REQ-032 Reset asserted mid-COUNT or mid-FAULT SHALL release berr_n and halt_n immediately, without waiting for a clock edge.
REQ-033 After reset_n rises, monitoring resumes on the first edge that sees enable=1 and as_n=0.

Verification
REQ-034 Defaults, as_n held low, dtack_n=1 -> berr_n low at edge 128 after COUNT entry, timeout pulse 1 cycle, fault_count=1; as_n high -> berr_n=1 on the next edge.
REQ-035 limit=10, dtack_n low at edge 5 -> IDLE, berr_n never asserted, fault_count unchanged; dtack_n low exactly at the timeout edge -> no fault.
REQ-036 RETRY_EN=1, two consecutive timed-out accesses -> first asserts berr_n=0 and halt_n=0, second asserts berr_n=0 only; a later access ended by dtack_n -> next timeout asserts halt_n again.
REQ-037 Counter at 50 with limit 100, write limit_in=20 -> FAULT on the next edge.
REQ-038 256 timeouts -> fault_count saturates at 255; fault_clr together with a timeout -> fault_count=1.
REQ-039 reset_n pulsed low mid-FAULT -> berr_n=1 asynchronously, limit_q=RESET_LIMIT, fault_count=0.
